clk_div_monitor: RTL
====================

Name: clk_div_monitor

Overview:
- Downstream checker for the clock divider: samples one divided clock (e.g. clk_div2 or clk_div3) in the source clk domain.
- Counts its rising edges over a fixed gate window of clk cycles and flags pass/fail against the expected division ratio.
- Used in bring-up and self-test to prove the divider outputs toggle at the right rate; treats the divided clock purely as data, never as a clock.

Parameters:
- GATE_CYCLES, 60: length of the measurement window in clk cycles.
- EXP_DIV, 3: expected division ratio of the monitored clock. Expected count = GATE_CYCLES/EXP_DIV, integer division, elaborated as a constant.
- TOL, 1: allowed absolute deviation of edge_count from the expected count.
- CNT_W, 8: width of the edge counter; must satisfy 2^CNT_W-1 >= GATE_CYCLES.

Ports:
- clk  input  1  source clock; the same clock that feeds the divider.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a measurement.
- clk_div_in  input  1  divided clock under test, sampled as data.
- busy  output  1  high from acceptance of start until done.
- done  output  1  one-cycle pulse when a result is valid.
- edge_count  output  CNT_W  rising edges counted in the last window.
- pass  output  1  result of the tolerance check; valid from done onward.
- high_count  output  CNT_W  present only with CLKMON_DUTY_EN.

Behaviour:
- Reset (synchronous, active-high; all registers clear on the clk edge where rst=1):
  - State goes to IDLE.
  - busy=0, done=0, pass=0, edge_count=0, high_count=0, synchronizer flops=0.
- Input path: clk_div_in passes through a 2-flop synchronizer (s1, s2) plus a previous-value flop p. Rising edge = s2 & ~p.
- FSM states: IDLE, ARM, MEASURE, REPORT.
- IDLE:
  - start=1 moves to ARM.
  - Clears the internal edge counter and window counter.
  - busy=1 from the next cycle.
- ARM: exactly 2 cycles to flush the synchronizer; no edges are counted. Then moves to MEASURE.
- MEASURE:
  - Exactly GATE_CYCLES cycles.
  - Each cycle with a detected rising edge increments the edge counter, which saturates at 2^CNT_W-1.
  - The window counter runs 0..GATE_CYCLES-1. At the last value, moves to REPORT.
- REPORT (1 cycle):
  - done=1.
  - edge_count <= edge counter.
  - pass <= (|counter - GATE_CYCLES/EXP_DIV| <= TOL), computed with a CNT_W+1-bit signed difference.
  - busy deasserts in the same cycle.
  - Returns to IDLE.
- Latency: done is high exactly GATE_CYCLES+3 clk cycles after the edge that sampled start.
- Holding: edge_count and pass hold their values until the next REPORT. They are not cleared by a new start.
- start while busy=1 is ignored (no queuing).
- start in the same cycle as REPORT is ignored. start is accepted in IDLE only.
- A stuck (constant) clk_div_in gives edge_count=0 and pass=0.
- rst in any state aborts the measurement: next state IDLE, no done pulse, outputs cleared.

Optional Feature:
- Macro: CLKMON_DUTY_EN.
- When defined:
  - The high_count port exists.
  - During MEASURE, a second saturating counter increments on every cycle with s2=1.
  - It is latched to high_count in REPORT and reset to 0.
  - pass is unaffected.
- When undefined: no port, no counter; behaviour is otherwise identical.

Decomposition:
- Package clk_mon_pkg:
  - State enum (IDLE, ARM, MEASURE, REPORT).
  - ARM_CYCLES=2 constant.
  - A function computing the expected count and the tolerance check.
- One natural sub-module: clk_mon_edge_sync, containing the 2-flop synchronizer, the prev flop and the rise output. It has clk and rst ports and is reused for any further monitored clocks.

Test Plan:
- Divider /3 on clk_div_in, default params, pulse start: done at start+63 cycles; edge_count in 19..21 (nominally 20); pass=1; busy high for 62 cycles.
- Divider /2 on clk_div_in with EXP_DIV=3: edge_count=30, pass=0. Rerun with EXP_DIV=2: pass=1.
- clk_div_in tied 0, then tied 1: edge_count=0, pass=0 both times; done still pulses at start+63.
- rst=1 for 1 cycle at 20 cycles into MEASURE: busy=0 and outputs=0 next cycle, no done. A fresh start gives a normal result at start+63.
- Extra start pulses at +5 and +62 cycles: ignored; exactly one done pulse. start at +63 (REPORT) ignored; start at +64 is accepted.
- With CLKMON_DUTY_EN: /2 input gives high_count=30; /3 input (1-high/2-low) gives high_count=20 ±1.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared FSM states, arm length and expected-count helpers for the clock-rate monitor
package clk_mon_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;
  localparam int ARM_CYCLES = 2;
  function automatic int exp_count(input int gate, input int div);
    return gate / div;
  endfunction
  function automatic logic in_tol(input int diff, input int tol);
    return (diff < 0 ? -diff : diff) <= tol;
  endfunction
endpackage

// File: rtl/clk_mon_edge_sync.sv
// clk_mon_edge_sync: 2-flop synchronizer plus rise detect for a monitored clock; level output only with CLKMON_DUTY_EN
module clk_mon_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
`ifdef CLKMON_DUTY_EN
  output logic level,
`endif
  output logic rise
);
  logic s1, s2, p;
  always_ff @(posedge clk)
    if (rst) {s1, s2, p} <= '0;
    else {s1, s2, p} <= {d, s1, s2};
`ifdef CLKMON_DUTY_EN
  assign level = s2;
`endif
  assign rise = s2 & ~p;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: counts rising edges of a divided clock over a gate window and checks the ratio; CLKMON_DUTY_EN adds high_count
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES = 60,
  parameter int EXP_DIV     = 3,
  parameter int TOL         = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clk_div_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
`ifdef CLKMON_DUTY_EN
  output logic [CNT_W-1:0] high_count,
`endif
  output logic             pass
);
  localparam int EXP_CNT = exp_count(GATE_CYCLES, EXP_DIV);
  state_t state, state_nxt;
  logic [CNT_W-1:0] win, edge_cnt;
  logic signed [CNT_W:0] diff;
  logic rise;
`ifdef CLKMON_DUTY_EN
  logic lvl;
  logic [CNT_W-1:0] hi_cnt;
`endif
  clk_mon_edge_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (clk_div_in),
`ifdef CLKMON_DUTY_EN
    .level (lvl),
`endif
    .rise  (rise)
  );
  assign diff = $signed({1'b0, edge_cnt}) - $signed((CNT_W+1)'(EXP_CNT));
  assign busy = state == ARM || state == MEASURE;
  always_comb begin
    state_nxt = state == IDLE    ? (start ? ARM : IDLE) :
                state == ARM     ? (win == CNT_W'(ARM_CYCLES-1) ? MEASURE : ARM) :
                state == MEASURE ? (win == CNT_W'(GATE_CYCLES-1) ? REPORT : MEASURE) :
                                   IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win        <= '0;
      edge_cnt   <= '0;
      done       <= 1'b0;
      edge_count <= '0;
      pass       <= 1'b0;
`ifdef CLKMON_DUTY_EN
      hi_cnt     <= '0;
      high_count <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= state == REPORT;
      // window counter restarts on every state change, so it times both ARM and MEASURE
      win   <= (state == IDLE || state_nxt != state) ? '0 : win + 1'b1;
      if (state == IDLE) edge_cnt <= '0;
      else if (state == MEASURE && rise && edge_cnt != '1) edge_cnt <= edge_cnt + 1'b1;
      if (state == REPORT) begin
        edge_count <= edge_cnt;
        pass       <= in_tol(int'(diff), TOL);
      end
`ifdef CLKMON_DUTY_EN
      if (state == REPORT) begin
        high_count <= hi_cnt;
        hi_cnt     <= '0;
      end else if (state == IDLE) hi_cnt <= '0;
      else if (state == MEASURE && lvl && hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
`endif
    end
  end
endmodule
